// File: rtl/aes_pkg.sv
// Shared AES-128 types, S-box tables and key-schedule helpers.
// Byte 0 of a block or key sits in bits [127:120]; words are column-major.
package aes_pkg;

   typedef logic [3:0][7:0]  t_aes_word;   // [3] is byte 0 of the word
   typedef logic [15:0][7:0] t_aes_state;  // [15] is state byte 0
   typedef t_aes_word [3:0]  t_aes_key;    // [3] is w0, the oldest word

   typedef enum logic [1:0] {IDLE, KEYEXP, DEC, DONE} t_fsm;

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   localparam logic [7:0] INV_SBOX [256] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };

   localparam logic [7:0] RCON [1:10] = '{
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
   };

   // Round counter values outside 1..10 only occur on unused paths; return 0 there.
   function automatic logic [7:0] get_rcon(logic [3:0] idx);
      return (idx >= 4'd1 && idx <= 4'd10) ? RCON[idx] : 8'h00;
   endfunction

   function automatic logic [7:0] xtime(logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   function automatic t_aes_word SubWord(t_aes_word w);
      t_aes_word r;
      for (int i = 0; i < 4; i++) r[i] = SBOX[w[i]];
      return r;
   endfunction

   function automatic t_aes_word RotWord(t_aes_word w);
      return {w[2], w[1], w[0], w[3]};
   endfunction

   function automatic t_aes_key expand(t_aes_key k, logic [7:0] rc);
      t_aes_key n;
      n[3] = k[3] ^ SubWord(RotWord(k[0])) ^ {rc, 24'h000000};
      n[2] = k[2] ^ n[3];
      n[1] = k[1] ^ n[2];
      n[0] = k[0] ^ n[1];
      return n;
   endfunction

   // Undo one expansion step: the older words fall out of pairwise XORs of the newer ones.
   function automatic t_aes_key inv_expand(t_aes_key k, logic [7:0] rc);
      t_aes_key p;
      p[0] = k[0] ^ k[1];
      p[1] = k[1] ^ k[2];
      p[2] = k[2] ^ k[3];
      p[3] = k[3] ^ SubWord(RotWord(p[0])) ^ {rc, 24'h000000};
      return p;
   endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless this is the final round.
module aes_inv_round
   import aes_pkg::*;
(
   input  t_aes_state state_i,
   input  t_aes_key   rk_i,
   input  logic       last_i,
   output t_aes_state state_o
);

   t_aes_state shifted;
   t_aes_state subbed;
   t_aes_state keyed;
   logic [7:0] a0, a1, a2, a3;

   // Row r rotates right by r, so the byte at column c comes from column c-r.
   always_comb begin
      shifted = '0;
      subbed  = '0;
      keyed   = '0;
      state_o = '0;
      a0 = 8'h00;
      a1 = 8'h00;
      a2 = 8'h00;
      a3 = 8'h00;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            shifted[15 - (r + 4 * c)] = state_i[15 - (r + 4 * ((c - r + 4) % 4))];
         end
      end
      for (int i = 0; i < 16; i++) subbed[i] = INV_SBOX[shifted[i]];
      keyed = subbed ^ rk_i;
      if (last_i) begin
         state_o = keyed;
      end else begin
         for (int c = 0; c < 4; c++) begin
            a0 = keyed[15 - 4 * c];
            a1 = keyed[14 - 4 * c];
            a2 = keyed[13 - 4 * c];
            a3 = keyed[12 - 4 * c];
            state_o[15 - 4 * c] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
            state_o[14 - 4 * c] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
            state_o[13 - 4 * c] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
            state_o[12 - 4 * c] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
         end
      end
   end

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 decryptor: one round per clock, forward key expansion to
// round key 10 followed by reverse expansion during the decryption rounds.
module aes_inv_cipher_iter
   import aes_pkg::*;
#(
   parameter int NR = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         key_reuse,
   input  logic [127:0] data,
   input  logic [127:0] key,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] o
);

   if (NR != 10) begin : g_nr_check
      $error("aes_inv_cipher_iter: NR must be 10 for AES-128");
   end

   localparam logic [3:0] LAST_RK  = 4'(NR);
   localparam logic [3:0] FIRST_DEC = 4'(NR - 1);

   t_fsm       fsm_q, fsm_d;
   t_aes_state cipher_q, cipher_d;
   t_aes_key   rk_q, rk_d;
   t_aes_key   rk10Cache_q, rk10Cache_d;
   logic       cacheValid_q, cacheValid_d;
   logic [3:0] cnt_q, cnt_d;

   t_aes_key   rkNext;
   t_aes_key   rkPrev;
   t_aes_state roundOut;

   assign rkNext = expand(rk_q, get_rcon(cnt_q));
   assign rkPrev = inv_expand(rk_q, get_rcon(cnt_q + 4'd1));

   aes_inv_round u_round (
      .state_i (cipher_q),
      .rk_i    (rkPrev),
      .last_i  (cnt_q == 4'd0),
      .state_o (roundOut)
   );

   assign in_ready  = (fsm_q == IDLE);
   assign out_valid = (fsm_q == DONE);
   assign o         = cipher_q;

   // The cipher register holds the raw ciphertext while the key is expanded forward.
   always_comb begin
      fsm_d        = fsm_q;
      cipher_d     = cipher_q;
      rk_d         = rk_q;
      rk10Cache_d  = rk10Cache_q;
      cacheValid_d = cacheValid_q;
      cnt_d        = cnt_q;
      unique case (fsm_q)
         IDLE: begin
            if (in_valid) begin
               if (key_reuse && cacheValid_q) begin
                  cipher_d = data ^ rk10Cache_q;
                  rk_d     = rk10Cache_q;
                  cnt_d    = FIRST_DEC;
                  fsm_d    = DEC;
               end else begin
                  cipher_d = data;
                  rk_d     = key;
                  cnt_d    = 4'd1;
                  fsm_d    = KEYEXP;
               end
            end
         end
         KEYEXP: begin
            rk_d  = rkNext;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == LAST_RK) begin
               cipher_d     = cipher_q ^ rkNext;
               rk10Cache_d  = rkNext;
               cacheValid_d = 1'b1;
               cnt_d        = FIRST_DEC;
               fsm_d        = DEC;
            end
         end
         DEC: begin
            cipher_d = roundOut;
            rk_d     = rkPrev;
            cnt_d    = cnt_q - 4'd1;
            if (cnt_q == 4'd0) fsm_d = DONE;
         end
         DONE: begin
            if (out_ready) fsm_d = IDLE;
         end
         default: fsm_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         fsm_q        <= IDLE;
         cipher_q     <= '0;
         rk_q         <= '0;
         rk10Cache_q  <= '0;
         cacheValid_q <= 1'b0;
         cnt_q        <= 4'd0;
      end else begin
         fsm_q        <= fsm_d;
         cipher_q     <= cipher_d;
         rk_q         <= rk_d;
         rk10Cache_q  <= rk10Cache_d;
         cacheValid_q <= cacheValid_d;
         cnt_q        <= cnt_d;
      end
   end

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Self-checking bench for aes_inv_cipher_iter: FIPS-197 vectors, back-pressure,
// reset corner cases and a random regression against a forward AES model.
module tb_aes_inv_cipher_iter;

   localparam logic [127:0] C1K = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] C1P = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] BK  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] BC  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] BP  = 128'h3243f6a8885a308d313198a2e0370734;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic         key_reuse;
   logic [127:0] data;
   logic [127:0] key;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] o;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [127:0] key;
      logic [127:0] data;
      logic         reuse;
      logic [127:0] expO;
      int           expLat;
   } t_vec;

   typedef struct {
      logic [127:0] o;
      int           lat;
   } t_exp;

   t_exp         sbq[$];
   t_vec         vecs[6];
   logic [7:0]   sbx[256];
   bit           cacheValid;
   logic [127:0] cacheKey;

   aes_inv_cipher_iter #(.NR(10)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .key_reuse (key_reuse),
      .data      (data),
      .key       (key),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .o         (o)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time exhausted, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [7:0] tbXtime(logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] tbMul(logic [7:0] a, logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = tbXtime(x);
      end
      return p;
   endfunction

   // S-box derived from the GF(2^8) inverse and the affine map, independent of the RTL tables.
   task automatic buildSbox();
      logic [7:0] inv;
      logic [7:0] b;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++) begin
            if (tbMul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         end
         b = inv;
         sbx[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
      end
   endtask

   function automatic logic [127:0] aesEncrypt(input logic [127:0] k128, input logic [127:0] pt);
      logic [7:0]   s[16];
      logic [7:0]   k[16];
      logic [7:0]   t[16];
      logic [7:0]   rc;
      logic [7:0]   a0, a1, a2, a3;
      logic [127:0] res;
      for (int i = 0; i < 16; i++) begin
         k[i] = k128[127 - 8 * i -: 8];
         s[i] = pt[127 - 8 * i -: 8] ^ k[i];
      end
      rc = 8'h01;
      for (int r = 1; r <= 10; r++) begin
         a0 = sbx[k[13]] ^ rc;
         a1 = sbx[k[14]];
         a2 = sbx[k[15]];
         a3 = sbx[k[12]];
         k[0] = k[0] ^ a0;
         k[1] = k[1] ^ a1;
         k[2] = k[2] ^ a2;
         k[3] = k[3] ^ a3;
         for (int i = 4; i < 16; i++) k[i] = k[i] ^ k[i - 4];
         rc = tbXtime(rc);
         for (int i = 0; i < 16; i++) t[i] = sbx[s[(i % 4) + 4 * (((i / 4) + (i % 4)) % 4)]];
         for (int c = 0; c < 4; c++) begin
            a0 = t[4 * c];
            a1 = t[4 * c + 1];
            a2 = t[4 * c + 2];
            a3 = t[4 * c + 3];
            if (r < 10) begin
               s[4 * c]     = tbXtime(a0) ^ tbXtime(a1) ^ a1 ^ a2 ^ a3;
               s[4 * c + 1] = a0 ^ tbXtime(a1) ^ tbXtime(a2) ^ a2 ^ a3;
               s[4 * c + 2] = a0 ^ a1 ^ tbXtime(a2) ^ tbXtime(a3) ^ a3;
               s[4 * c + 3] = tbXtime(a0) ^ a0 ^ a1 ^ a2 ^ tbXtime(a3);
            end else begin
               s[4 * c]     = a0;
               s[4 * c + 1] = a1;
               s[4 * c + 2] = a2;
               s[4 * c + 3] = a3;
            end
         end
         for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[i];
      end
      for (int i = 0; i < 16; i++) res[127 - 8 * i -: 8] = s[i];
      return res;
   endfunction

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic applyReset();
      rst       = 1'b0;
      in_valid  = 1'b0;
      key_reuse = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("reset_in_ready", 128'(in_ready), 128'd1);
      checkOutput("reset_out_valid", 128'(out_valid), 128'd0);
      checkOutput("reset_o", o, 128'd0);
      rst = 1'b1;
      cacheValid = 1'b0;
   endtask

   // Drives one block, pushes its expectation and updates the key-cache model.
   task automatic applyStimulus(input logic [127:0] k, input logic [127:0] d, input logic reuse,
                                input logic [127:0] expO, input int expLat);
      int waitCnt = 0;
      while (!in_ready && waitCnt < 50) begin
         @(negedge clk);
         waitCnt++;
      end
      checkOutput("accept_ready", 128'(in_ready), 128'd1);
      in_valid  = 1'b1;
      key       = k;
      data      = d;
      key_reuse = reuse;
      @(negedge clk);
      in_valid  = 1'b0;
      key_reuse = 1'b0;
      sbq.push_back('{expO, expLat});
      if (!(reuse && cacheValid)) begin
         cacheKey   = k;
         cacheValid = 1'b1;
      end
   endtask

   task automatic collectOutput(input bit randomReady);
      int   lat = 0;
      int   hold;
      t_exp e;
      while (!out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      if (sbq.size() == 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL scoreboard: got empty queue, expected a pending block");
         return;
      end
      e = sbq.pop_front();
      checkOutput("latency", 128'(lat), 128'(e.lat));
      checkOutput("plaintext", o, e.o);
      hold = (randomReady && $urandom_range(0, 1) == 1) ? int'($urandom_range(1, 4)) : 0;
      if (hold > 0) begin
         out_ready = 1'b0;
         for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checkOutput("hold_valid", 128'(out_valid), 128'd1);
            checkOutput("hold_o", o, e.o);
         end
      end
      out_ready = 1'b1;
      @(negedge clk);
      checkOutput("release_valid", 128'(out_valid), 128'd0);
      checkOutput("release_ready", 128'(in_ready), 128'd1);
   endtask

   initial begin
      int           lat;
      logic [127:0] rk;
      logic [127:0] pt;
      logic         reuse;
      bit           hit;

      buildSbox();
      data = '0;
      key  = '0;
      applyReset();

      vecs[0] = '{C1K,    C1C, 1'b1, C1P, 20};
      vecs[1] = '{BK,     BC,  1'b0, BP,  20};
      vecs[2] = '{128'd0, BC,  1'b1, BP,  10};
      vecs[3] = '{C1K,    C1C, 1'b0, C1P, 20};
      vecs[4] = '{128'd0, C1C, 1'b1, C1P, 10};
      vecs[5] = '{BK,     C1C, 1'b1, C1P, 10};
      for (int i = 0; i < 6; i++) begin
         applyStimulus(vecs[i].key, vecs[i].data, vecs[i].reuse, vecs[i].expO, vecs[i].expLat);
         collectOutput(1'b0);
      end

      // Back-pressure with a second request waiting on in_valid the whole time.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      key       = C1K;
      data      = C1C;
      key_reuse = 1'b0;
      @(negedge clk);
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      checkOutput("bp_latency", 128'(lat), 128'd20);
      for (int i = 0; i < 7; i++) begin
         checkOutput("bp_o", o, C1P);
         checkOutput("bp_in_ready", 128'(in_ready), 128'd0);
         @(negedge clk);
      end
      checkOutput("bp_valid_held", 128'(out_valid), 128'd1);
      out_ready = 1'b1;
      @(negedge clk);
      checkOutput("bp_release_valid", 128'(out_valid), 128'd0);
      checkOutput("bp_idle_ready", 128'(in_ready), 128'd1);
      @(negedge clk);
      checkOutput("bp_second_capture", 128'(in_ready), 128'd0);
      in_valid = 1'b0;
      sbq.push_back('{C1P, 20});
      cacheKey   = C1K;
      cacheValid = 1'b1;
      collectOutput(1'b0);

      // Reset during DEC at cnt=5 aborts the block and clears the key cache.
      applyStimulus(C1K, C1C, 1'b0, C1P, 20);
      repeat (14) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("midreset_in_ready", 128'(in_ready), 128'd1);
      checkOutput("midreset_out_valid", 128'(out_valid), 128'd0);
      checkOutput("midreset_o", o, 128'd0);
      rst = 1'b1;
      sbq.delete();
      cacheValid = 1'b0;
      applyStimulus(C1K, C1C, 1'b1, C1P, 20);
      collectOutput(1'b0);

      // A request offered in the reset cycle must not be captured.
      rst      = 1'b0;
      in_valid = 1'b1;
      key      = BK;
      data     = BC;
      @(negedge clk);
      in_valid = 1'b0;
      rst      = 1'b1;
      cacheValid = 1'b0;
      @(negedge clk);
      checkOutput("rstvalid_in_ready", 128'(in_ready), 128'd1);
      checkOutput("rstvalid_out_valid", 128'(out_valid), 128'd0);

      for (int n = 0; n < 200; n++) begin
         rk    = {$urandom, $urandom, $urandom, $urandom};
         pt    = {$urandom, $urandom, $urandom, $urandom};
         reuse = ($urandom_range(0, 3) == 0);
         hit   = reuse && cacheValid;
         applyStimulus(rk, aesEncrypt(hit ? cacheKey : rk, pt), reuse, pt, hit ? 10 : 20);
         collectOutput(1'b1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
